temp_datapath: RTL
==================

// Module: temp_datapath
// PURPOSE
// - Datapath stage that feeds the heat/cool controller FSM: consumes datapath_in1/2/3 (troom, tref, dt) and produces datapath_out[3:0].
// - Smooths troom with a 2^AVG_LOG2-sample moving average and compares the average against saturated thresholds tref-dt, tref+dt and tref.
// - Registers the comparison flags so the controller sees a stable decision; flags are held at zero until the averaging window is full.
// PARAMETERS
// - WIDTH     7  bit width of troom, tref, dt and avg_temp (unsigned)
// - AVG_LOG2  2  log2 of the averaging window depth (DEPTH = 4)
// PORTS
// - clk           in   1      system clock, rising edge
// - reset         in   1      asynchronous, active-low reset
// - sample_en     in   1      capture datapath_in1 into the window on this edge
// - flush         in   1      synchronous clear of window, sum, count and flags
// - datapath_in1  in   WIDTH  troom, room temperature sample
// - datapath_in2  in   WIDTH  tref, reference temperature
// - datapath_in3  in   WIDTH  dt, hysteresis band
// - datapath_out  out  4      [0] too cold, [1] too hot, [2] heat done, [3] cool done
// - avg_temp      out  WIDTH  current window average (sum >> AVG_LOG2)
// - ready         out  1      window holds DEPTH valid samples
// BEHAVIOUR
// - Reset (reset=0, async): window, sum, fill count, datapath_out and ready all go to 0; avg_temp reads 0.
// - Window: shift register of DEPTH samples plus a running sum of WIDTH+AVG_LOG2 bits.
//   - On an edge with sample_en=1: sum <= sum + troom - oldest; troom is shifted in and oldest is shifted out.
//   - Empty slots hold 0, so partial sums are exact during warm-up.
// - Fill count saturates at DEPTH; ready = (count == DEPTH).
// - flush=1 clears window, sum, count and datapath_out on that edge.
//   - flush has priority over sample_en; a sample presented in the same cycle is discarded.
// - Thresholds, computed combinationally from the current tref and dt:
//   - low  = tref - dt, saturating at 0
//   - high = tref + dt, saturating at 2^WIDTH-1
//   - Use WIDTH+1-bit intermediates; no wrap-around is permitted.
// - Flags, registered every clock from avg_temp and the thresholds:
//   - f0 = avg < low
//   - f1 = avg > high
//   - f2 = avg >= tref
//   - f3 = avg <= tref
// - datapath_out <= ready ? {f3,f2,f1,f0} : 4'b0000. It updates every edge, not only on sample_en.
// - Latency:
//   - Sample captured at edge k: sum, avg_temp and ready update at edge k.
//   - datapath_out reflects that sample at edge k+1.
//   - A change on tref or dt alone reaches datapath_out at the next edge.
// - Consistency: f0 and f1 are never both 1. f0=1 implies f3=1, and f1=1 implies f2=1.
//   - If dt=0, then low = high = tref.
// - Saturation: if low saturates to 0, f0 stays 0; if high saturates to 2^WIDTH-1, f1 stays 0.
// - Reset mid-operation returns to the empty window. The first valid flags appear one edge after the DEPTH-th new sample.
// - There is no internal FSM beyond the warm-up count (EMPTY -> FILLING -> READY, held in count).
// STRUCTURE
// - Shared package temp_pkg:
//   - flag index constants FLG_COLD=0, FLG_HOT=1, FLG_HEAT_DONE=2, FLG_COOL_DONE=3
//   - default WIDTH
//   - same package used by temp_controller
// - Sub-module temp_avg_window:
//   - contains shift register, running sum, fill count and ready
//   - parameterised by WIDTH and AVG_LOG2
// - Top level holds the threshold arithmetic and the flag register.
// TESTING
// - tref=25, dt=3; 3 samples of 20 -> ready=0, datapath_out=0000. 4th sample -> ready=1, avg=20, next edge datapath_out=1001.
// - Window full of 30, tref=25, dt=3 -> avg=30, datapath_out=0110. Then 4 samples of 25 -> datapath_out=1100.
// - tref=5, dt=10, avg=0 -> low saturates to 0, f0=0, datapath_out=1000. tref=120, dt=20, avg=127 -> f1=0, datapath_out=0100.
// - Samples 20,22,24,26 -> sum=92, avg=23. Then a 5th sample of 30 -> sum=102, avg=25 (oldest value 20 dropped).
// - Full window, then flush=1 together with sample_en=1 -> next edge ready=0, sum=0, datapath_out=0000, sample discarded.
// - reset pulsed low mid-operation, asynchronous to clk -> all outputs 0 immediately; warm-up of 4 samples required again.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared constants for the temperature datapath and its controller.
// Flag indices name the bits of datapath_out.
package temp_pkg;

  localparam int TEMP_WIDTH    = 7;
  localparam int TEMP_AVG_LOG2 = 2;

  localparam int FLG_COLD      = 0;
  localparam int FLG_HOT       = 1;
  localparam int FLG_HEAT_DONE = 2;
  localparam int FLG_COOL_DONE = 3;

  typedef logic [3:0] temp_flags_t;

endpackage

// File: rtl/temp_datapath_if.sv
// Bus between the temperature datapath and whatever drives its samples and
// references. The driver side uses master; the datapath uses slave.
interface temp_datapath_if
  import temp_pkg::*;
#(
  parameter int WIDTH = TEMP_WIDTH
);

  logic              sample_en;
  logic              flush;
  logic [WIDTH-1:0]  datapath_in1;
  logic [WIDTH-1:0]  datapath_in2;
  logic [WIDTH-1:0]  datapath_in3;
  temp_flags_t       datapath_out;
  logic [WIDTH-1:0]  avg_temp;
  logic              ready;

  modport master (
    output sample_en, flush, datapath_in1, datapath_in2, datapath_in3,
    input  datapath_out, avg_temp, ready
  );

  modport slave (
    input  sample_en, flush, datapath_in1, datapath_in2, datapath_in3,
    output datapath_out, avg_temp, ready
  );

endinterface

// File: rtl/temp_avg_window.sv
// Moving-average window: DEPTH-sample shift register, exact running sum and a
// saturating fill count that raises ready once the window is full.
module temp_avg_window
  import temp_pkg::*;
#(
  parameter int WIDTH    = TEMP_WIDTH,
  parameter int AVG_LOG2 = TEMP_AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] avg_o,
  output logic             ready_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = WIDTH + AVG_LOG2;
  localparam int CW    = AVG_LOG2 + 1;

  logic [WIDTH-1:0] window_q [DEPTH];
  logic [SW-1:0]    sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;

  // The oldest sample leaves as the new one enters, so the sum never underflows.
  assign sum_d   = sum_q + SW'(sample_i) - SW'(window_q[DEPTH-1]);
  assign count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);

  // NOTE: the window storage is reset on purpose: empty slots must read 0 so
  // the partial sum stays exact during warm-up.
  // NOTE: all state here uses non-blocking assignments so the shift reads the
  // previous slot values, not ones updated earlier in the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) window_q[i] <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) window_q[i] <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else if (sample_en_i) begin
      window_q[0] <= sample_i;
      for (int i = 1; i < DEPTH; i++) window_q[i] <= window_q[i-1];
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign avg_o   = sum_q[SW-1:AVG_LOG2];
  assign ready_o = (count_q == CW'(DEPTH));

endmodule

// File: rtl/temp_datapath.sv
// Averages troom, compares it against saturated tref+/-dt thresholds and
// registers the heat/cool decision flags for the controller.
module temp_datapath
  import temp_pkg::*;
#(
  parameter int WIDTH    = TEMP_WIDTH,
  parameter int AVG_LOG2 = TEMP_AVG_LOG2
) (
  input  logic            clk,
  input  logic            reset,
  temp_datapath_if.slave  dp
);

  logic [WIDTH-1:0] avg;
  logic             ready;
  logic [WIDTH:0]   low_ext, high_ext;
  logic [WIDTH-1:0] low, high, tref;
  temp_flags_t      flags, dout_q, dout_d;

  temp_avg_window #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .sample_en_i (dp.sample_en),
    .flush_i     (dp.flush),
    .sample_i    (dp.datapath_in1),
    .avg_o       (avg),
    .ready_o     (ready)
  );

  assign tref = dp.datapath_in2;

  // One extra bit exposes borrow/carry so both thresholds clamp instead of wrapping.
  assign low_ext  = {1'b0, tref} - {1'b0, dp.datapath_in3};
  assign high_ext = {1'b0, tref} + {1'b0, dp.datapath_in3};
  assign low      = low_ext[WIDTH]  ? '0 : low_ext[WIDTH-1:0];
  assign high     = high_ext[WIDTH] ? '1 : high_ext[WIDTH-1:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    flags                = '0;
    flags[FLG_COLD]      = (avg <  low);
    flags[FLG_HOT]       = (avg >  high);
    flags[FLG_HEAT_DONE] = (avg >= tref);
    flags[FLG_COOL_DONE] = (avg <= tref);
  end

  assign dout_d = (dp.flush || !ready) ? '0 : flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dp.datapath_out = dout_q;
  assign dp.avg_temp     = avg;
  assign dp.ready        = ready;

endmodule
